hazard_stall_ctrl: RTL and testbench

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

---
 rtl/hazard_pkg.sv | 16 +
 rtl/hazard_stall_ctrl_if.sv | 33 +++
 rtl/lat_counter.sv | 26 ++
 rtl/hazard_stall_ctrl.sv | 125 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard/stall controller: load-stall FSM
// encoding, default latencies and counter widths.
package hazard_pkg;

  localparam int unsigned STATE_W = 1;
  localparam logic [STATE_W-1:0] IDLE       = 1'b0;
  localparam logic [STATE_W-1:0] LOAD_STALL = 1'b1;

  localparam int unsigned DEFAULT_LOAD_LAT   = 1;
  localparam int unsigned DEFAULT_MULDIV_LAT = 32;

  // Widths cover the legal latency ranges (load 1..7, mult/div 1..63).
  localparam int unsigned LOAD_CNT_W = 3;
  localparam int unsigned MD_CNT_W   = 6;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side signal bundle for the hazard/stall controller.
// master = pipeline datapath, slave = controller.
interface hazard_stall_ctrl_if #(
  parameter int unsigned ADDR_W = 5
);

  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic              useRs;
  logic              useRt;
  logic [ADDR_W-1:0] rtEX;
  logic              memRead;
  logic              isBranch;
  logic              mulDivStart;
  logic              useHiLo;
  logic              pcWrite;
  logic              ifIdWrite;
  logic              idExBubble;
  logic              ifIdFlush;
  logic              mulDivBusy;
  logic [31:0]       stallCycles;

  modport master (
    output rs, rt, useRs, useRt, rtEX, memRead, isBranch, mulDivStart, useHiLo,
    input  pcWrite, ifIdWrite, idExBubble, ifIdFlush, mulDivBusy, stallCycles
  );

  modport slave (
    input  rs, rt, useRs, useRt, rtEX, memRead, isBranch, mulDivStart, useHiLo,
    output pcWrite, ifIdWrite, idExBubble, ifIdFlush, mulDivBusy, stallCycles
  );

endinterface

// File: rtl/lat_counter.sv
// Loadable down-counter that stops at zero; load has priority over decrement.
module lat_counter #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] loadVal,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] countQ;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      countQ <= '0;
    end else if (load) begin
      countQ <= loadVal;
    end else if (countQ != '0) begin
      countQ <= countQ - 1'b1;
    end
  end

  assign count = countQ;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use and HI/LO-busy stalls, branch flush
// deferral, and a saturating stall-cycle performance counter.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned LOAD_LAT   = DEFAULT_LOAD_LAT,
  parameter int unsigned MULDIV_LAT = DEFAULT_MULDIV_LAT
) (
  input  logic                Clock,
  input  logic                Reset,
  hazard_stall_ctrl_if.slave  bus
);

  logic [ADDR_W-1:0]     rs;
  logic [ADDR_W-1:0]     rt;
  logic [ADDR_W-1:0]     rtEX;
  logic                  loadHazard;
  logic [STATE_W-1:0]    stateQ;
  logic [STATE_W-1:0]    stateD;
  logic                  loadCntLoad;
  logic [LOAD_CNT_W-1:0] loadCnt;
  logic [MD_CNT_W-1:0]   mdCnt;
  logic                  loadStall;
  logic                  mdStall;
  logic                  mulDivBusy;
  logic                  stallRaw;
  logic                  stall;
  logic                  branchPendQ;
  logic [31:0]           stallCntQ;

  assign rs   = bus.rs;
  assign rt   = bus.rt;
  assign rtEX = bus.rtEX;

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign loadHazard = bus.memRead & (rtEX != '0) &
                      ((bus.useRs & (rs == rtEX)) | (bus.useRt & (rt == rtEX)));

  always_comb begin
    stateD      = stateQ;
    loadCntLoad = 1'b0;
    loadStall   = 1'b0;
    case (stateQ)
      IDLE: begin
        if (loadHazard) begin
          loadStall = 1'b1;
          if (LOAD_LAT > 1) begin
            stateD      = LOAD_STALL;
            loadCntLoad = 1'b1;
          end
        end
      end
      LOAD_STALL: begin
        // EX holds a bubble here, so a fresh loadHazard is not looked at.
        loadStall = 1'b1;
        if (loadCnt <= LOAD_CNT_W'(1)) begin
          stateD = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  lat_counter #(
    .WIDTH (LOAD_CNT_W)
  ) u_load_cnt (
    .Clock   (Clock),
    .Reset   (Reset),
    .load    (loadCntLoad),
    .loadVal (LOAD_CNT_W'(LOAD_LAT - 1)),
    .count   (loadCnt)
  );

  lat_counter #(
    .WIDTH (MD_CNT_W)
  ) u_md_cnt (
    .Clock   (Clock),
    .Reset   (Reset),
    .load    (bus.mulDivStart),
    .loadVal (MD_CNT_W'(MULDIV_LAT)),
    .count   (mdCnt)
  );

  assign mulDivBusy = (mdCnt != '0);
  assign mdStall    = bus.useHiLo & mulDivBusy;
  assign stallRaw   = loadStall | mdStall;
  // Gate with Reset so outputs sit at their idle values while reset is held,
  // whatever the combinational hazard inputs are doing.
  assign stall      = Reset & stallRaw;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      branchPendQ <= 1'b0;
    end else if (stallRaw) begin
      branchPendQ <= branchPendQ | bus.isBranch;
    end else begin
      branchPendQ <= 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      stallCntQ <= '0;
    end else if (stallRaw && (stallCntQ != '1)) begin
      stallCntQ <= stallCntQ + 32'd1;
    end
  end

  assign bus.pcWrite     = ~stall;
  assign bus.ifIdWrite   = ~stall;
  assign bus.idExBubble  = stall;
  assign bus.ifIdFlush   = Reset & (bus.isBranch | branchPendQ) & ~stallRaw;
  assign bus.mulDivBusy  = mulDivBusy;
  assign bus.stallCycles = stallCntQ;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with LOAD_LAT=2, MULDIV_LAT=4.
module tb_hazard_stall_ctrl;

  logic Clock;
  logic Reset;
  int   checks;
  int   failures;

  hazard_stall_ctrl_if #(.ADDR_W(5)) bus ();

  hazard_stall_ctrl #(
    .ADDR_W     (5),
    .LOAD_LAT   (2),
    .MULDIV_LAT (4)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        useRs;
    logic        useRt;
    logic [4:0]  rtEX;
    logic        memRead;
    logic        isBranch;
    logic        expPc;
    logic        expFlush;
    logic [31:0] expSc;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic useRs,
                              input logic useRt, input logic [4:0] rtEX, input logic memRead,
                              input logic isBranch, input logic expPc, input logic expFlush,
                              input logic [31:0] expSc);
    vec_t v;
    v.rs = rs; v.rt = rt; v.useRs = useRs; v.useRt = useRt; v.rtEX = rtEX;
    v.memRead = memRead; v.isBranch = isBranch;
    v.expPc = expPc; v.expFlush = expFlush; v.expSc = expSc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic checkCtl(input string name, input logic pc, input logic flush, input logic busy,
                          input logic [31:0] sc);
    check({name, " pcWrite"}, 32'(bus.pcWrite), 32'(pc));
    check({name, " ifIdWrite"}, 32'(bus.ifIdWrite), 32'(pc));
    check({name, " idExBubble"}, 32'(bus.idExBubble), 32'(!pc));
    check({name, " ifIdFlush"}, 32'(bus.ifIdFlush), 32'(flush));
    check({name, " mulDivBusy"}, 32'(bus.mulDivBusy), 32'(busy));
    check({name, " stallCycles"}, bus.stallCycles, sc);
  endtask

  task automatic setIn(input logic [4:0] rs, input logic [4:0] rt, input logic useRs,
                       input logic useRt, input logic [4:0] rtEX, input logic memRead,
                       input logic isBranch, input logic mulDivStart, input logic useHiLo);
    bus.rs = rs; bus.rt = rt; bus.useRs = useRs; bus.useRt = useRt; bus.rtEX = rtEX;
    bus.memRead = memRead; bus.isBranch = isBranch;
    bus.mulDivStart = mulDivStart; bus.useHiLo = useHiLo;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //           rs  rt  uRs uRt rtEX mR  br   pc  fl  sc
    vecs[0]  = mk(0,  0,  0,  0,  0,   0,  0,   1,  0,  0);
    vecs[1]  = mk(0,  0,  1,  1,  0,   1,  0,   1,  0,  0);  // r0 load: no hazard
    vecs[2]  = mk(15, 0,  1,  0,  15,  1,  0,   0,  0,  0);  // rs load-use
    vecs[3]  = mk(0,  0,  0,  0,  0,   0,  0,   0,  0,  1);
    vecs[4]  = mk(0,  0,  0,  0,  0,   0,  0,   1,  0,  2);
    vecs[5]  = mk(0,  7,  0,  1,  7,   1,  0,   0,  0,  2);  // rt load-use
    vecs[6]  = mk(0,  7,  0,  1,  7,   1,  0,   0,  0,  3);  // hazard ignored in LOAD_STALL
    vecs[7]  = mk(0,  0,  0,  0,  0,   0,  0,   1,  0,  4);
    vecs[8]  = mk(9,  3,  0,  1,  9,   1,  0,   1,  0,  4);  // match but rs unused
    vecs[9]  = mk(9,  0,  1,  0,  9,   0,  0,   1,  0,  4);  // match but not a load
    vecs[10] = mk(0,  0,  0,  0,  0,   0,  1,   1,  1,  4);  // plain branch flush
    vecs[11] = mk(15, 0,  1,  0,  15,  1,  1,   0,  0,  4);  // branch during stall
    vecs[12] = mk(0,  0,  0,  0,  0,   0,  0,   0,  0,  5);
    vecs[13] = mk(0,  0,  0,  0,  0,   0,  0,   1,  1,  6);  // deferred flush
    vecs[14] = mk(0,  0,  0,  0,  0,   0,  0,   1,  0,  6);

    // Reset held with hazard-looking inputs: outputs must stay idle.
    Reset = 1'b0;
    setIn(15, 15, 1, 1, 15, 1, 1, 1, 1);
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    checkCtl("reset", 1'b1, 1'b0, 1'b0, 32'd0);
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 Reset = 1'b1;
    @(posedge Clock);
    #1;

    for (int i = 0; i < 15; i++) begin
      setIn(vecs[i].rs, vecs[i].rt, vecs[i].useRs, vecs[i].useRt, vecs[i].rtEX,
            vecs[i].memRead, vecs[i].isBranch, 1'b0, 1'b0);
      @(negedge Clock);
      checkCtl($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expFlush, 1'b0, vecs[i].expSc);
      @(posedge Clock);
      #1;
    end

    // Single mult/div: busy and HI/LO stall for exactly 4 cycles.
    for (int c = 0; c < 6; c++) begin
      setIn(0, 0, 0, 0, 0, 0, 0, (c == 0), 1'b1);
      @(negedge Clock);
      checkCtl($sformatf("md1 c%0d", c), !(c >= 1 && c <= 4), 1'b0, (c >= 1 && c <= 4),
               32'd6 + 32'((c > 4) ? 4 : (c > 0 ? c - 1 : 0)));
      @(posedge Clock);
      #1;
    end

    // Restart at cycle 2 while busy: busy extends through cycle 6.
    for (int c = 0; c < 8; c++) begin
      setIn(0, 0, 0, 0, 0, 0, 0, (c == 0 || c == 2), 1'b1);
      @(negedge Clock);
      checkCtl($sformatf("md2 c%0d", c), !(c >= 1 && c <= 6), 1'b0, (c >= 1 && c <= 6),
               32'd10 + 32'((c > 6) ? 6 : (c > 0 ? c - 1 : 0)));
      @(posedge Clock);
      #1;
    end

    // Async reset during the second LOAD_STALL cycle.
    setIn(15, 0, 1, 0, 15, 1, 1, 0, 0);
    @(negedge Clock);
    checkCtl("rst pre", 1'b0, 1'b0, 1'b0, 32'd16);
    @(posedge Clock);
    #2;
    check("rst stall2 pcWrite", 32'(bus.pcWrite), 32'd0);
    Reset = 1'b0;
    #1;
    checkCtl("rst async", 1'b1, 1'b0, 1'b0, 32'd0);
    @(negedge Clock);
    checkCtl("rst held", 1'b1, 1'b0, 1'b0, 32'd0);
    #1 Reset = 1'b1;
    #1;
    checkCtl("rel idle", 1'b0, 1'b0, 1'b0, 32'd0);
    @(posedge Clock);
    #1;
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge Clock);
    checkCtl("rel stall2", 1'b0, 1'b0, 1'b0, 32'd1);
    @(posedge Clock);
    #1;
    @(negedge Clock);
    checkCtl("rel done", 1'b1, 1'b1, 1'b0, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
